// File: rtl/bp_me_lce_id_to_cord.sv
// LCE id -> coherence-NoC cord {y, x} plus in-tile cache index.
// Core-complex ids get their row/column split by repeated subtraction of cc_x_dim_p.
//
// state  | meaning
// IDLE   | ready for a request; captures lce_id_i on v_i
// DECODE | classify the captured id by region
// DIV    | core-complex only: subtract cc_x_dim_p until rem < cc_x_dim_p
// DONE   | result valid; held until yumi_i
module bp_me_lce_id_to_cord #(
  parameter int cc_x_dim_p             = 2,
  parameter int cc_y_dim_p             = 2,
  parameter int sac_x_dim_p            = 1,
  parameter int ic_y_dim_p             = 1,
  parameter int num_cacc_p             = 2,
  parameter int num_l2e_p              = 2,
  parameter int num_sacc_p             = 2,
  parameter int num_io_p               = 2,
  parameter int lce_id_width_p         = 5,
  parameter int coh_noc_x_cord_width_p = 4,
  parameter int coh_noc_y_cord_width_p = 4
) (
  input  logic                                                     clk_i,
  input  logic                                                     reset_n_i,
  input  logic [lce_id_width_p-1:0]                                lce_id_i,
  input  logic                                                     v_i,
  output logic                                                     ready_o,
  output logic [coh_noc_y_cord_width_p+coh_noc_x_cord_width_p-1:0] cord_o,
  output logic                                                     cid_o,
  output logic                                                     err_o,
  output logic                                                     v_o,
  input  logic                                                     yumi_i
);

  localparam int LW       = lce_id_width_p;
  localparam int XW       = coh_noc_x_cord_width_p;
  localparam int YW       = coh_noc_y_cord_width_p;
  localparam int NUM_CORE = cc_x_dim_p * cc_y_dim_p;
  localparam int MAX_CC   = 2 * NUM_CORE;
  localparam int MAX_CAC  = MAX_CC + num_cacc_p;
  localparam int MAX_MC   = MAX_CAC + num_l2e_p;
  localparam int MAX_SAC  = MAX_MC + num_sacc_p;
  localparam int MAX_IC   = MAX_SAC + num_io_p;
  localparam int RW       = $clog2(NUM_CORE + 1);

  localparam logic [LW-1:0] MAX_CC_L  = LW'(MAX_CC);
  localparam logic [LW-1:0] MAX_CAC_L = LW'(MAX_CAC);
  localparam logic [LW-1:0] MAX_MC_L  = LW'(MAX_MC);
  localparam logic [LW-1:0] MAX_SAC_L = LW'(MAX_SAC);
  localparam logic [LW-1:0] MAX_IC_L  = LW'(MAX_IC);
  localparam logic [XW-1:0] X_SAC     = XW'(sac_x_dim_p);
  localparam logic [XW-1:0] X_CAC     = XW'(sac_x_dim_p + cc_x_dim_p);
  localparam logic [YW-1:0] Y_IC      = YW'(ic_y_dim_p);
  localparam logic [YW-1:0] Y_MC      = YW'(ic_y_dim_p + cc_y_dim_p);
  localparam logic [RW-1:0] CC_X_R    = RW'(cc_x_dim_p);

  typedef enum logic [1:0] {IDLE, DECODE, DIV, DONE} state_e;

  state_e          state_q, state_d;
  logic            started_q;
  logic [LW-1:0]   id_q, id_d;
  logic [RW-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            cid_q, cid_d, err_q, err_d;
  logic [LW-1:0]   off_cac, off_mc, off_sac, off_io;

  assign off_cac = id_q - MAX_CC_L;
  assign off_mc  = id_q - MAX_CAC_L;
  assign off_sac = id_q - MAX_MC_L;
  assign off_io  = id_q - MAX_SAC_L;

  // started_q keeps ready_o low until the first edge after reset release
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (v_i && started_q) state_d = DECODE;
      DECODE:  state_d = (id_q < MAX_CC_L) ? DIV : DONE;
      DIV:     if (rem_q < CC_X_R) state_d = DONE;
      DONE:    if (yumi_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE) && started_q;
    v_o     = (state_q == DONE);
  end

  always_comb begin
    id_d  = id_q;
    rem_d = rem_q;
    quo_d = quo_q;
    x_d   = x_q;
    y_d   = y_q;
    cid_d = cid_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (v_i && started_q) id_d = lce_id_i;
      DECODE: begin
        err_d = 1'b0;
        cid_d = 1'b0;
        if (id_q < MAX_CC_L) begin
          cid_d = id_q[0];
          rem_d = RW'(id_q >> 1);
          quo_d = '0;
        end else if (id_q < MAX_CAC_L) begin
          x_d = X_CAC;
          y_d = Y_IC + YW'(off_cac);
        end else if (id_q < MAX_MC_L) begin
          x_d = X_SAC + XW'(off_mc);
          y_d = Y_MC;
        end else if (id_q < MAX_SAC_L) begin
          x_d = '0;
          y_d = Y_IC + YW'(off_sac);
        end else if (id_q < MAX_IC_L) begin
          x_d = X_SAC + XW'(off_io);
          y_d = '0;
        end else begin
          err_d = 1'b1;
          x_d   = '0;
          y_d   = '0;
        end
      end
      DIV: begin
        if (rem_q >= CC_X_R) begin
          rem_d = rem_q - CC_X_R;
          quo_d = quo_q + RW'(1);
        end else begin
          x_d = X_SAC + XW'(rem_q);
          y_d = Y_IC + YW'(quo_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      id_q  <= '0;
      rem_q <= '0;
      quo_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      cid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      id_q  <= id_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cid_q <= cid_d;
      err_q <= err_d;
    end
  end

  assign cord_o = {y_q, x_q};
  assign cid_o  = cid_q;
  assign err_o  = err_q;

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
  v_i_known:        assert property (@(posedge clk_i) disable iff (!reset_n_i) !$isunknown(v_i));

endmodule
